// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common-data-bus writeback arbiter and the ROB rename width.
package cdb_arbiter_pkg;

    localparam int unsigned NREQ = 4;
    localparam int unsigned RNW  = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned SRCW = 2;

    localparam int unsigned ALU1  = 0;
    localparam int unsigned ALU2  = 1;
    localparam int unsigned LOAD  = 2;
    localparam int unsigned STORE = 3;

    // Round-robin successor of index w among n requesters.
    function automatic int unsigned next_ptr(input int unsigned w, input int unsigned n);
        return (w + 1 >= n) ? 0 : w + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first valid requester at or after rr_ptr wins.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [PW-1:0]   rr_ptr,
    output logic [NREQ-1:0] grant
);

    int unsigned   idx;
    logic [PW-1:0] sel;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            sel = PW'(idx);
            if (!found && req_valid[sel]) begin
                grant[sel] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB writeback arbiter: round-robin grant among execution units, one registered
// writeback per cycle, with stall (rdy) and mispredict flush handling.
module cdb_arbiter #(
    parameter int unsigned NREQ = cdb_arbiter_pkg::NREQ,
    parameter int unsigned RNW  = cdb_arbiter_pkg::RNW,
    parameter int unsigned DW   = cdb_arbiter_pkg::DW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               rob_flush,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*RNW-1:0] req_rename,
    input  logic [NREQ*DW-1:0] req_value,
    output logic [NREQ-1:0]    req_ready,
    output logic               wb_flag,
    output logic [RNW-1:0]     wb_rename,
    output logic [DW-1:0]      wb_value,
    output logic [1:0]         wb_src,
    output logic               wb_is_store
);

    import cdb_arbiter_pkg::*;

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0] grant;
    logic            grant_en;
    logic            any_grant;
    logic [PW-1:0]   win_idx;
    logic            win_store;
    logic [RNW-1:0]  win_tag;
    logic [DW-1:0]   win_val;

    logic            wb_flag_q;
    logic [RNW-1:0]  wb_rename_q;
    logic [DW-1:0]   wb_value_q;
    logic [1:0]      wb_src_q;
    logic            wb_is_store_q;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_arbiter (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant)
    );

    // Ready only when the transfer can actually complete at this edge.
    assign grant_en  = rdy & ~rob_flush & ~rst;
    assign req_ready = grant & {NREQ{grant_en}};
    assign any_grant = |req_ready;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                win_idx = PW'(i);
            end
        end
    end

    assign win_store = (win_idx == PW'(STORE));
    assign win_tag   = req_rename[win_idx*RNW +: RNW];
    assign win_val   = win_store ? '0 : req_value[win_idx*DW +: DW];
    assign rr_ptr_d  = PW'(next_ptr(32'(win_idx), NREQ));

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q      <= '0;
            wb_flag_q     <= 1'b0;
            wb_rename_q   <= '0;
            wb_value_q    <= '0;
            wb_src_q      <= '0;
            wb_is_store_q <= 1'b0;
        end else if (rdy) begin
            if (rob_flush) begin
                rr_ptr_q  <= '0;
                wb_flag_q <= 1'b0;
            end else if (any_grant) begin
                rr_ptr_q      <= rr_ptr_d;
                wb_flag_q     <= 1'b1;
                wb_rename_q   <= win_tag;
                wb_value_q    <= win_val;
                wb_src_q      <= 2'(win_idx);
                wb_is_store_q <= win_store;
            end else begin
                wb_flag_q <= 1'b0;
            end
        end
    end

    assign wb_flag     = wb_flag_q;
    assign wb_rename   = wb_rename_q;
    assign wb_value    = wb_value_q;
    assign wb_src      = wb_src_q;
    assign wb_is_store = wb_is_store_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural round-robin model.
module tb_cdb_arbiter;

    localparam int NREQ = 4;
    localparam int RNW  = 4;
    localparam int DW   = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst, rdy, rob_flush;
    logic [NREQ-1:0]     req_valid;
    logic [RNW-1:0]      tag [NREQ];
    logic [DW-1:0]       val [NREQ];
    logic [NREQ*RNW-1:0] req_rename;
    logic [NREQ*DW-1:0]  req_value;
    logic [NREQ-1:0]     req_ready;
    logic                wb_flag;
    logic [RNW-1:0]      wb_rename;
    logic [DW-1:0]       wb_value;
    logic [1:0]          wb_src;
    logic                wb_is_store;

    always_comb begin
        req_rename = '0;
        req_value  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_rename[i*RNW +: RNW] = tag[i];
            req_value[i*DW +: DW]    = val[i];
        end
    end

    cdb_arbiter #(.NREQ(NREQ), .RNW(RNW), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .rob_flush   (rob_flush),
        .req_valid   (req_valid),
        .req_rename  (req_rename),
        .req_value   (req_value),
        .req_ready   (req_ready),
        .wb_flag     (wb_flag),
        .wb_rename   (wb_rename),
        .wb_value    (wb_value),
        .wb_src      (wb_src),
        .wb_is_store (wb_is_store)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int             m_ptr = 0;
    logic           m_flag = 1'b0;
    logic [RNW-1:0] m_tag = '0;
    logic [DW-1:0]  m_val = '0;
    logic [1:0]     m_src = '0;
    logic           m_store = 1'b0;

    function automatic int model_grant();
        if (rst || !rdy || rob_flush) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int g);
        logic [3:0] one;
        one = 4'b0001;
        if (g < 0) return 4'b0000;
        return one << g;
    endfunction

    task automatic tick();
        int g;
        g = model_grant();
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_flag = 0; m_tag = '0; m_val = '0; m_src = '0; m_store = 0;
        end else if (rdy) begin
            if (rob_flush) begin
                m_flag = 0;
                m_ptr  = 0;
            end else if (g >= 0) begin
                m_flag  = 1;
                m_tag   = tag[g];
                m_val   = (g == 3) ? '0 : val[g];
                m_src   = 2'(g);
                m_store = (g == 3);
                m_ptr   = (g + 1) % NREQ;
            end else begin
                m_flag = 0;
            end
        end
        #1;
    endtask

    task automatic set_in(input logic r, input logic rd, input logic fl, input logic [3:0] v);
        rst = r; rdy = rd; rob_flush = fl; req_valid = v;
        #1;
    endtask

    task automatic do_reset();
        set_in(1, 1, 0, 4'b0000);
        tick();
    endtask

    task automatic test_reset();
        set_in(1, 1, 0, 4'b1111);
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_ready got=%b want=0000", req_ready);
        end
        tick(); tick();
        checks++;
        if ({wb_flag, wb_rename, wb_value, wb_src, wb_is_store} !== '0) begin
            errors++;
            $display("FAIL reset_wb got flag=%b tag=%h val=%h src=%0d st=%b want all 0",
                     wb_flag, wb_rename, wb_value, wb_src, wb_is_store);
        end
    endtask

    task automatic test_single();
        tag[0] = 4'd5; val[0] = 32'h1234;
        set_in(0, 1, 0, 4'b0001);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL single_ready got=%b want=0001", req_ready);
        end
        tick();
        checks++;
        if (wb_flag !== 1'b1 || wb_rename !== 4'd5 || wb_value !== 32'h1234 ||
            wb_src !== 2'd0 || wb_is_store !== 1'b0) begin
            errors++;
            $display("FAIL single_wb got flag=%b tag=%0d val=%h src=%0d st=%b want 1/5/1234/0/0",
                     wb_flag, wb_rename, wb_value, wb_src, wb_is_store);
        end
    endtask

    task automatic test_round_robin();
        int exp;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            tag[i] = 4'(i + 10); val[i] = 32'(100 + i);
        end
        set_in(0, 1, 0, 4'b1111);
        for (int c = 0; c < 5; c++) begin
            exp = c % NREQ;
            checks++;
            if (req_ready !== onehot(exp)) begin
                errors++; $display("FAIL rr_ready[%0d] got=%b want=%b", c, req_ready, onehot(exp));
            end
            tick();
            checks++;
            if (wb_flag !== 1'b1 || wb_src !== 2'(exp) || wb_rename !== 4'(exp + 10)) begin
                errors++;
                $display("FAIL rr_wb[%0d] got flag=%b src=%0d tag=%0d want 1/%0d/%0d",
                         c, wb_flag, wb_src, wb_rename, exp, exp + 10);
            end
        end
    endtask

    task automatic test_store();
        do_reset();
        tag[3] = 4'd9; val[3] = 32'hDEADBEEF;
        set_in(0, 1, 0, 4'b1000);
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++; $display("FAIL store_ready got=%b want=1000", req_ready);
        end
        tick();
        checks++;
        if (wb_flag !== 1'b1 || wb_value !== 32'h0 || wb_is_store !== 1'b1 ||
            wb_src !== 2'd3 || wb_rename !== 4'd9) begin
            errors++;
            $display("FAIL store_wb got flag=%b val=%h st=%b src=%0d tag=%0d want 1/0/1/3/9",
                     wb_flag, wb_value, wb_is_store, wb_src, wb_rename);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        set_in(0, 1, 0, 4'b0100);
        tick();
        set_in(0, 1, 0, 4'b1000);
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++; $display("FAIL wrap_grant3 got=%b want=1000", req_ready);
        end
        tick();
        set_in(0, 1, 0, 4'b0011);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL wrap_to0 got=%b want=0001", req_ready);
        end
        tick();
        checks++;
        if (wb_flag !== 1'b1 || wb_src !== 2'd0) begin
            errors++; $display("FAIL wrap_wb got flag=%b src=%0d want 1/0", wb_flag, wb_src);
        end
    endtask

    task automatic test_flush();
        do_reset();
        set_in(0, 1, 0, 4'b0100);
        tick();
        set_in(0, 1, 1, 4'b0100);
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL flush_ready got=%b want=0000", req_ready);
        end
        tick();
        checks++;
        if (wb_flag !== 1'b0) begin
            errors++; $display("FAIL flush_wb_flag got=%b want=0", wb_flag);
        end
        set_in(0, 1, 0, 4'b1100);
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL flush_ptr_reset got=%b want=0100", req_ready);
        end
        tick();
        checks++;
        if (wb_flag !== 1'b1 || wb_src !== 2'd2) begin
            errors++; $display("FAIL flush_next_wb got flag=%b src=%0d want 1/2", wb_flag, wb_src);
        end
    endtask

    task automatic test_stall();
        do_reset();
        tag[0] = 4'd7; val[0] = 32'h77;
        tag[1] = 4'd3; val[1] = 32'h55;
        set_in(0, 1, 0, 4'b0001);
        tick();
        set_in(0, 0, 0, 4'b0010);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++; $display("FAIL stall_ready[%0d] got=%b want=0000", c, req_ready);
            end
            tick();
            checks++;
            if (wb_flag !== 1'b1 || wb_rename !== 4'd7 || wb_value !== 32'h77 || wb_src !== 2'd0) begin
                errors++;
                $display("FAIL stall_frozen[%0d] got flag=%b tag=%0d val=%h src=%0d want 1/7/77/0",
                         c, wb_flag, wb_rename, wb_value, wb_src);
            end
        end
        set_in(0, 1, 0, 4'b0010);
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL stall_resume_ready got=%b want=0010", req_ready);
        end
        tick();
        checks++;
        if (wb_flag !== 1'b1 || wb_src !== 2'd1 || wb_rename !== 4'd3 || wb_value !== 32'h55) begin
            errors++;
            $display("FAIL stall_resume_wb got flag=%b src=%0d tag=%0d val=%h want 1/1/3/55",
                     wb_flag, wb_src, wb_rename, wb_value);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_in(0, 1, 0, 4'b0100);
        tick();
        set_in(1, 1, 0, 4'b1000);
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL midrst_ready got=%b want=0000", req_ready);
        end
        tick();
        checks++;
        if ({wb_flag, wb_rename, wb_value, wb_src, wb_is_store} !== '0) begin
            errors++;
            $display("FAIL midrst_wb got flag=%b tag=%h val=%h src=%0d st=%b want all 0",
                     wb_flag, wb_rename, wb_value, wb_src, wb_is_store);
        end
        set_in(0, 1, 0, 4'b1111);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL midrst_first_grant got=%b want=0001", req_ready);
        end
        tick();
    endtask

    task automatic test_random();
        int g;
        int waits [NREQ];
        logic [3:0] exp_ready;
        for (int i = 0; i < NREQ; i++) waits[i] = 0;
        req_valid = '0;
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 59) == 0);
            rdy       = ($urandom_range(0, 7) != 0);
            rob_flush = ($urandom_range(0, 19) == 0);
            // Requesters hold valid/tag/value until transferred; idle ones may start.
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    req_valid[i] = 1'b1;
                    tag[i] = 4'($urandom);
                    val[i] = $urandom;
                    waits[i] = 0;
                end
            end
            #1;
            g = model_grant();
            exp_ready = onehot(g);
            checks++;
            if (req_ready !== exp_ready) begin
                errors++; $display("FAIL rand_ready[%0d] got=%b want=%b", c, req_ready, exp_ready);
            end
            if (g >= 0) begin
                checks++;
                if (waits[g] > NREQ - 1) begin
                    errors++;
                    $display("FAIL rand_fairness[%0d] req=%0d waited=%0d want<=%0d",
                             c, g, waits[g], NREQ - 1);
                end
            end
            if (!rst && rdy && !rob_flush) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (req_valid[i] && i != g) waits[i]++;
                end
            end
            tick();
            checks++;
            if (wb_flag !== m_flag || wb_rename !== m_tag || wb_value !== m_val ||
                wb_src !== m_src || wb_is_store !== m_store) begin
                errors++;
                $display("FAIL rand_wb[%0d] got %b/%h/%h/%0d/%b want %b/%h/%h/%0d/%b", c,
                         wb_flag, wb_rename, wb_value, wb_src, wb_is_store,
                         m_flag, m_tag, m_val, m_src, m_store);
            end
            if (rst || (rdy && rob_flush)) begin
                req_valid = '0;
            end else if (g >= 0) begin
                req_valid[g] = 1'b0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            tag[i] = '0; val[i] = '0;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_store();
        test_wrap();
        test_flush();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
